// File: rtl/sseg_scan_controller_if.sv
// Load-side bus of the seven-segment scan controller: value, load strobe and busy.
interface sseg_scan_controller_if;
  logic [9:0] number;
  logic       load;
  logic       busy;

  modport master (output number, output load, input busy);
  modport slave  (input number, input load, output busy);
endinterface

// File: rtl/sseg_scan_controller.sv
// 4-digit seven-segment controller: iterative binary-to-BCD conversion on load,
// then a free-running digit scan with optional leading-zero blanking.
module sseg_scan_controller #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  sseg_scan_controller_if.slave  bus,
  output logic [7:0]             sseg_o,
  output logic [3:0]             anodes_o
);

  localparam int unsigned BIN_W    = 10;
  localparam int unsigned BCD_W    = 16;
  localparam int unsigned BITCNT_W = 4;
  localparam int unsigned REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BCD_W-1:0]      digits_q, digits_d;
  logic                  busy_q, busy_d;
  logic [BCD_W-1:0]      bcd_adj;

  logic [REF_W-1:0]      refresh_q;
  logic [1:0]            idx_q;
  logic [3:0]            digit_c;
  logic                  blank_c;
  logic [7:0]            seg_c;
  logic [3:0]            anodes_c;

  // Double-dabble correction: bump every nibble >= 5 by 3 before the shift
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = v;
    for (int i = 0; i < 4; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = 4'(nib + 4'd3);
      end
    end
    return r;
  endfunction

  assign bcd_adj = add3(bcd_q);

  // Conversion state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      digits_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      digits_q  <= digits_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath updates; SHIFT spends one extra cycle after the
  // tenth shift before handing over to COMMIT
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    digits_d  = digits_q;

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          bin_d     = bus.number;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == BITCNT_W'(BIN_W)) begin
          state_d = S_COMMIT;
        end else begin
          {bcd_d, bin_d} = (BCD_W + BIN_W)'({bcd_adj, bin_q} << 1);
          bit_cnt_d      = BITCNT_W'(bit_cnt_q + BITCNT_W'(1));
        end
      end
      S_COMMIT: begin
        digits_d = bcd_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.busy = busy_q;

  // Digit selection and leading-zero blanking for the current scan index
  always_comb begin
    digit_c = digits_q[4*idx_q +: 4];
    blank_c = 1'b0;
    if (BLANK_LEADING) begin
      case (idx_q)
        2'd3:    blank_c = (digits_q[15:12] == 4'd0);
        2'd2:    blank_c = (digits_q[15:8]  == 8'd0);
        2'd1:    blank_c = (digits_q[15:4]  == 12'd0);
        default: blank_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    seg_c = 8'hFF;
    if (!blank_c) begin
      case (digit_c)
        4'd0:    seg_c = 8'hC0;
        4'd1:    seg_c = 8'hF9;
        4'd2:    seg_c = 8'hA4;
        4'd3:    seg_c = 8'hB0;
        4'd4:    seg_c = 8'h99;
        4'd5:    seg_c = 8'h92;
        4'd6:    seg_c = 8'h82;
        4'd7:    seg_c = 8'hF8;
        4'd8:    seg_c = 8'h80;
        4'd9:    seg_c = 8'h90;
        default: seg_c = 8'hFF;
      endcase
    end
  end

  assign anodes_c = ~(4'b0001 << idx_q);

  // Refresh timer, digit index and registered pin drive (segments and anode
  // share one edge so they can never disagree)
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
      sseg_o    <= 8'hFF;
      anodes_o  <= 4'hF;
    end else begin
      if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        idx_q     <= 2'(idx_q + 2'd1);
      end else begin
        refresh_q <= REF_W'(refresh_q + REF_W'(1));
      end
      sseg_o   <= seg_c;
      anodes_o <= anodes_c;
    end
  end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Scoreboard bench: loads queue their expected display value and commit time;
// a monitor checks pins and busy every cycle against a decimal-arithmetic model.
module tb_sseg_scan_controller;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] number = '0;
  logic       load = 1'b0;

  logic [7:0] sseg_b, sseg_n;
  logic [3:0] an_b, an_n;

  sseg_scan_controller_if bus_b ();
  sseg_scan_controller_if bus_n ();

  assign bus_b.number = number;
  assign bus_b.load   = load;
  assign bus_n.number = number;
  assign bus_n.load   = load;

  sseg_scan_controller #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .sseg_o(sseg_b), .anodes_o(an_b)
  );

  sseg_scan_controller #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n.slave), .sseg_o(sseg_n), .anodes_o(an_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int commit_edge;
  } pend_t;

  pend_t pend_q[$];
  int    edge_n   = 0;
  int    last_rst = 0;
  int    last_acc = -100;
  int    disp_val = 0;
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Digit idx of value v in decimal; blank if it is a leading zero
  function automatic logic [7:0] exp_seg(input int v, input int idx, input bit blank);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (blank && idx > 0 && v < p) return 8'hFF;
    return seg_code((v / p) % 10);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at edge %0d: actual=%h required=%h", name, edge_n, act, exp_v);
    end
  endtask

  // Monitor: compare outputs after each edge, then retire a commit due at this edge
  initial begin : monitor
    bit          rs;
    int          idx;
    logic [7:0]  eb;
    pend_t       p;
    forever begin
      @(posedge clk);
      edge_n++;
      rs = rst;
      #1;
      if (rs) begin
        check("rst_seg_b", sseg_b, 8'hFF);
        check("rst_an_b", {4'h0, an_b}, 8'h0F);
        check("rst_busy_b", {7'd0, bus_b.busy}, 8'd0);
        check("rst_seg_n", sseg_n, 8'hFF);
        check("rst_an_n", {4'h0, an_n}, 8'h0F);
        last_rst = edge_n;
        last_acc = -100;
        pend_q.delete();
        disp_val = 0;
      end else begin
        idx = ((edge_n - last_rst - 1) / DIV) % 4;
        eb  = {7'd0, (edge_n >= last_acc) && (edge_n < last_acc + 12)};
        check("busy_b", {7'd0, bus_b.busy}, eb);
        check("busy_n", {7'd0, bus_n.busy}, eb);
        check("anodes_b", {4'h0, an_b}, {4'h0, ~(4'b0001 << idx)});
        check("anodes_n", {4'h0, an_n}, {4'h0, ~(4'b0001 << idx)});
        check("seg_blank", sseg_b, exp_seg(disp_val, idx, 1'b1));
        check("seg_noblank", sseg_n, exp_seg(disp_val, idx, 1'b0));
        if (pend_q.size() > 0 && pend_q[0].commit_edge == edge_n) begin
          p = pend_q.pop_front();
          disp_val = p.val;
        end
      end
    end
  end

  // Stimulus tasks start and end at a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_load(input logic [9:0] v);
    int    e;
    pend_t p;
    number = v;
    load   = 1'b1;
    e = edge_n + 1;
    if (!rst && e > last_acc + 12) begin
      last_acc      = e;
      p.val         = int'(v);
      p.commit_edge = e + 12;
      pend_q.push_back(p);
    end
    @(negedge clk);
    load   = 1'b0;
    number = 10'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !(edge_n + 1 > last_acc + 12); i++) @(negedge clk);
  endtask

  task automatic do_reset(input int n, input bit with_load);
    rst    = 1'b1;
    load   = with_load;
    number = 10'd77;
    repeat (n) @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
  endtask

  initial begin : stim
    int r;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick(20);

    issue_load(10'd1023);
    tick(44);

    wait_idle();
    issue_load(10'd305);
    tick(40);

    wait_idle();
    issue_load(10'd7);
    tick(4);
    issue_load(10'd999);
    tick(40);

    wait_idle();
    issue_load(10'd512);
    tick(5);
    do_reset(1, 1'b0);
    tick(20);

    do_reset(1, 1'b1);
    tick(20);

    wait_idle();
    issue_load(10'd0);
    wait_idle();
    issue_load(10'd1000);
    wait_idle();
    issue_load(10'd0);
    tick(40);

    wait_idle();
    issue_load(10'd1000);
    tick(40);

    repeat (30) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        do_reset(int'($urandom_range(1, 2)), 1'($urandom));
      end else if (r < 3) begin
        issue_load(10'($urandom));
      end else begin
        wait_idle();
        issue_load(10'($urandom));
      end
      tick(int'($urandom_range(0, 40)));
    end
    tick(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan_controller.md
# sseg_scan_controller

Sequencing controller for the calculator's 4-digit seven-segment display. It accepts a 10-bit binary result on a load strobe and converts it to four BCD digits with an iterative shift-add-3 sequence, one bit per clock. It then time-multiplexes the digits across the four common anodes with leading-zero blanking. It sits between the calculator datapath and the board's `sseg_o`/`anodes_o` pins. It replaces the static single-digit drive with a full multi-digit scan.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is held active (1 kHz per digit at 50 MHz). Must be ≥ 2.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros; 0 always shows all four digits.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `number`  in  10  unsigned binary value to display, 0..1023
- `load`  in  1  single-cycle request to convert and display `number`
- `busy`  out  1  conversion in progress; `load` is ignored while high
- `sseg_o`  out  8  segment drive, active-low, bit 7 = DP (always 1), bits 6:0 = g..a
- `anodes_o`  out  4  digit enables, active-low, bit 0 = rightmost (units) digit

## Operation
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: when `load`=1, capture `number` into a 10-bit shift register, clear the 16-bit BCD accumulator and the bit counter, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, bin} left by 1. After the 10th shift, go to COMMIT.
  - COMMIT: copy the four BCD nibbles into the display registers `d3..d0`, then return to IDLE.
- `busy` = 1 in SHIFT and COMMIT, 0 in IDLE.
- A `load` while not in IDLE is dropped, not queued. The display registers keep the previous value until COMMIT.
- The maximum input is 1023, so `d3` is 0 or 1. No overflow is possible.
- Scan logic runs independently of the FSM:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
- Blanking when `BLANK_LEADING`=1:
  - `d3` blank if `d3`=0.
  - `d2` blank if `d3`=`d2`=0.
  - `d1` blank if `d3`=`d2`=`d1`=0.
  - `d0` is never blank.
  - Internal zeros are shown. A blank digit drives `sseg_o`=FF with its anode still low.
- Segment codes (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF. Nibble values >9 cannot occur; if they do, drive FF.
- `anodes_o` has exactly one bit low at all times after the first post-reset cycle: index 0→1110, 1→1101, 2→1011, 3→0111.

## Timing
- Reset values:
  - State IDLE, `busy`=0, shift/BCD registers 0, `d3..d0`=0, digit index 0, refresh counter 0.
  - `sseg_o`=FF, `anodes_o`=1111 on the reset cycle.
- `sseg_o` and `anodes_o` are registered from the current index and display registers, so they lag the index by one cycle. Both update on the same edge, so segment data and anode never mismatch.
- Load latency, with `load` sampled high at edge E0:
  - E0: enter SHIFT, `busy`=1.
  - E1..E10: the ten shift iterations.
  - E11: enter COMMIT; the digits are written to `d3..d0` on the edge that leaves COMMIT (E12), when `busy` falls to 0.
  - A new `load` is accepted at E13 at the earliest.
  - New digits appear on `sseg_o` at the first register update after E12 in which the index selects that digit.
- The digit period is exactly REFRESH_DIV cycles, and the full frame is 4×REFRESH_DIV.
- `rst` mid-conversion aborts it. All state returns to reset values, and the display shows a single "0" after reset.
- `rst` and `load` together: reset wins and `load` is lost.

## Test plan
- Reset: hold `rst` 2 cycles. Check `anodes_o`=1111, `sseg_o`=FF, `busy`=0. One cycle after release, check `anodes_o`=1110 and `sseg_o`=C0, with digits 1–3 blank (FF) across a frame.
- Load 1023 (REFRESH_DIV=4). Check `busy` high for exactly 12 cycles. Over one frame, check anodes 1110/1101/1011/0111 with `sseg_o` B0/A4/C0/F9, each held 4 cycles.
- Load 305. Check digits 0..3 = 92, C0, B0, FF; the internal zero is displayed and the leading digit is blank. Repeat with BLANK_LEADING=0 and check digit 3 = C0.
- Load 7, then pulse `load` with `number`=999 at cycle 5 of the conversion. Check that the second load is ignored, the display shows only F8 on digit 0, and `busy` does not extend.
- Assert `rst` at cycle 6 of converting 512. Check the immediate return to reset values, with no 512 ever displayed and `busy`=0.
- Load 0, then 1000, then 0 back-to-back, each issued as soon as `busy` drops. Check each final display: "0" → F9,C0,C0,C0 → "0".
